// File: rtl/enc_arb_pkg.sv
// Shared types and helpers for the 8-way request arbiter.
package enc_arb_pkg;

    localparam int unsigned N   = 8;
    localparam int unsigned IDW = 3;

    typedef enum logic [1:0] {StIdle, StGrant, StGap} arb_state_e;

    function automatic logic [N-1:0] id_to_onehot(input logic [IDW-1:0] id);
        logic [N-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rot_prio_pick.sv
// Rotating MSB-first priority pick: searches start_id-1 downward (mod N) when rr_en,
// otherwise a plain highest-index-wins encode.
module rot_prio_pick
    import enc_arb_pkg::*;
(
    input  logic [N-1:0]   eff,
    input  logic [IDW-1:0] start_id,
    input  logic           rr_en,
    output logic           hit,
    output logic [IDW-1:0] id
);

    logic [IDW-1:0] base;
    logic [N-1:0]   rot;
    logic [IDW-1:0] pos;

    always_comb begin
        base = rr_en ? start_id : '0;
        // rot[j] = eff[j + base], so eff[base-1] lands on the MSB
        rot  = '0;
        for (int j = 0; j < N; j++) begin
            rot[j] = eff[IDW'(j) + base];
        end
        hit = |rot;
        pos = '0;
        for (int j = 0; j < N; j++) begin
            if (rot[j]) pos = IDW'(j);
        end
        id = pos + base;
    end

endmodule

// File: rtl/enc_req_arbiter.sv
// 8-way arbiter with fixed / round-robin selection, held grants, a bounded hold time
// and a one-cycle turnaround gap between grants.
module enc_req_arbiter
    import enc_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           mode,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic           preempt
);

    localparam int unsigned HCW = $clog2(MAX_HOLD + 1);

    arb_state_e     state;
    logic [IDW-1:0] last_id;
    logic [HCW-1:0] hold_cnt;
    logic [N-1:0]   mask;
    logic [N-1:0]   eff;
    logic           pick_hit;
    logic [IDW-1:0] pick_id;

    assign eff = req & ~mask;

    // mode feeds the picker directly; its result is only consumed in StIdle
    rot_prio_pick u_pick (
        .eff      (eff),
        .start_id (last_id),
        .rr_en    (mode),
        .hit      (pick_hit),
        .id       (pick_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
            last_id   <= '0;
            hold_cnt  <= '0;
            mask      <= '0;
        end else begin
            preempt <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (pick_hit) begin
                        state     <= StGrant;
                        gnt       <= id_to_onehot(pick_id);
                        gnt_id    <= pick_id;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= HCW'(1);
                        last_id   <= pick_id;
                    end
                    // Clears both on a win and when only masked requesters remain
                    mask <= '0;
                end
                StGrant: begin
                    if (!req[gnt_id]) begin
                        state     <= StGap;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                    end else if (hold_cnt == HCW'(MAX_HOLD)) begin
                        state     <= StGap;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        preempt   <= 1'b1;
                        mask      <= id_to_onehot(gnt_id);
                    end else begin
                        hold_cnt <= hold_cnt + HCW'(1);
                    end
                end
                StGap: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enc_req_arbiter.sv
// Directed bench for enc_req_arbiter; per-cycle expectations go through a scoreboard queue.
module tb_enc_req_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       mode;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       preempt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] id;
        logic       v;
        logic       p;
    } exp_t;

    exp_t sb[$];

    enc_req_arbiter #(.MAX_HOLD(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mode      (mode),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, queue the outputs expected after the next edge, then check.
    task automatic cyc(input string tag, input logic r, input logic [7:0] rq, input logic m,
                       input logic [7:0] eg, input logic [2:0] eid, input logic ev,
                       input logic ep);
        exp_t e;
        rst  = r;
        req  = rq;
        mode = m;
        sb.push_back('{gnt: eg, id: eid, v: ev, p: ep});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        assert (gnt === e.gnt) else begin
            errors++;
            $error("FAIL %s gnt got %b exp %b", tag, gnt, e.gnt);
        end
        checks++;
        assert (gnt_id === e.id) else begin
            errors++;
            $error("FAIL %s gnt_id got %0d exp %0d", tag, gnt_id, e.id);
        end
        checks++;
        assert (gnt_valid === e.v) else begin
            errors++;
            $error("FAIL %s gnt_valid got %b exp %b", tag, gnt_valid, e.v);
        end
        checks++;
        assert (preempt === e.p) else begin
            errors++;
            $error("FAIL %s preempt got %b exp %b", tag, preempt, e.p);
        end
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        mode = 1'b0;
        @(negedge clk);
        cyc("reset", 1, 8'h00, 0, 8'h00, 3'd0, 0, 0);

        // Fixed priority: 5 beats 2, release, gap, then 2
        cyc("fix_g5",   0, 8'b0010_0101, 0, 8'h20, 3'd5, 1, 0);
        cyc("fix_rel5", 0, 8'b0000_0101, 0, 8'h00, 3'd5, 0, 0);
        cyc("fix_gap",  0, 8'b0000_0101, 0, 8'h00, 3'd5, 0, 0);
        cyc("fix_g2",   0, 8'b0000_0101, 0, 8'h04, 3'd2, 1, 0);
        cyc("fix_rel2", 0, 8'h00,        0, 8'h00, 3'd2, 0, 0);
        cyc("fix_gap2", 0, 8'h00,        0, 8'h00, 3'd2, 0, 0);

        for (int i = 0; i < 10; i++) cyc("empty", 0, 8'h00, 0, 8'h00, 3'd2, 0, 0);

        // Reset mid-grant, then an immediate grant proves the state is IDLE
        cyc("rst_g3",   0, 8'h08, 0, 8'h08, 3'd3, 1, 0);
        cyc("rst_hold", 0, 8'h08, 0, 8'h08, 3'd3, 1, 0);
        cyc("rst_mid",  1, 8'h08, 0, 8'h00, 3'd0, 0, 0);
        cyc("rst_idle", 0, 8'h08, 0, 8'h08, 3'd3, 1, 0);
        cyc("rst_rel",  0, 8'h00, 0, 8'h00, 3'd3, 0, 0);
        cyc("rst_gap",  0, 8'h00, 0, 8'h00, 3'd3, 0, 0);

        // Hold limit: 16 grant cycles, preempt, 5 masked so 2 wins, then 5 again
        cyc("hold_g5", 0, 8'h25, 0, 8'h20, 3'd5, 1, 0);
        for (int i = 0; i < 15; i++) cyc("hold_run", 0, 8'h25, 0, 8'h20, 3'd5, 1, 0);
        cyc("hold_pre",  0, 8'h25, 0, 8'h00, 3'd5, 0, 1);
        cyc("hold_gap",  0, 8'h25, 0, 8'h00, 3'd5, 0, 0);
        cyc("hold_g2",   0, 8'h25, 0, 8'h04, 3'd2, 1, 0);
        cyc("hold_rel2", 0, 8'h21, 0, 8'h00, 3'd2, 0, 0);
        cyc("hold_gap2", 0, 8'h21, 0, 8'h00, 3'd2, 0, 0);
        cyc("hold_re5",  0, 8'h21, 0, 8'h20, 3'd5, 1, 0);
        cyc("hold_rel5", 0, 8'h00, 0, 8'h00, 3'd5, 0, 0);
        cyc("hold_gap3", 0, 8'h00, 0, 8'h00, 3'd5, 0, 0);

        // Lone preempted requester: mask clears on an empty IDLE, then 5 wins again
        cyc("lone_g5", 0, 8'h20, 0, 8'h20, 3'd5, 1, 0);
        for (int i = 0; i < 15; i++) cyc("lone_run", 0, 8'h20, 0, 8'h20, 3'd5, 1, 0);
        cyc("lone_pre",  0, 8'h20, 0, 8'h00, 3'd5, 0, 1);
        cyc("lone_gap",  0, 8'h20, 0, 8'h00, 3'd5, 0, 0);
        cyc("lone_clr",  0, 8'h20, 0, 8'h00, 3'd5, 0, 0);
        cyc("lone_g5b",  0, 8'h20, 0, 8'h20, 3'd5, 1, 0);
        cyc("lone_rel",  0, 8'h00, 0, 8'h00, 3'd5, 0, 0);
        cyc("lone_gap2", 0, 8'h00, 0, 8'h00, 3'd5, 0, 0);

        // Coincident release on the limit cycle: no preempt, no mask
        cyc("coin_g5", 0, 8'h25, 0, 8'h20, 3'd5, 1, 0);
        for (int i = 0; i < 15; i++) cyc("coin_run", 0, 8'h25, 0, 8'h20, 3'd5, 1, 0);
        cyc("coin_rel",  0, 8'h05, 0, 8'h00, 3'd5, 0, 0);
        cyc("coin_gap",  0, 8'h25, 0, 8'h00, 3'd5, 0, 0);
        cyc("coin_g5b",  0, 8'h25, 0, 8'h20, 3'd5, 1, 0);
        cyc("coin_rel2", 0, 8'h00, 0, 8'h00, 3'd5, 0, 0);
        cyc("coin_gap2", 0, 8'h00, 0, 8'h00, 3'd5, 0, 0);

        // Round robin from last_id=5: 0, then 7, then 5 despite 7 requesting
        cyc("rr_g0",   0, 8'hA1, 1, 8'h01, 3'd0, 1, 0);
        cyc("rr_rel0", 0, 8'hA0, 1, 8'h00, 3'd0, 0, 0);
        cyc("rr_gap0", 0, 8'hA0, 1, 8'h00, 3'd0, 0, 0);
        cyc("rr_g7",   0, 8'hA0, 1, 8'h80, 3'd7, 1, 0);
        cyc("rr_rel7", 0, 8'h20, 1, 8'h00, 3'd7, 0, 0);
        cyc("rr_gap7", 0, 8'hA0, 1, 8'h00, 3'd7, 0, 0);
        cyc("rr_g5",   0, 8'hA0, 1, 8'h20, 3'd5, 1, 0);
        cyc("rr_rel5", 0, 8'h00, 1, 8'h00, 3'd5, 0, 0);
        cyc("rr_gap5", 0, 8'h00, 1, 8'h00, 3'd5, 0, 0);

        // Mode toggled mid-grant on 6; next IDLE uses round robin from 6 so 5 beats 7
        cyc("mc_g6",   0, 8'h60, 0, 8'h40, 3'd6, 1, 0);
        cyc("mc_tog",  0, 8'h60, 1, 8'h40, 3'd6, 1, 0);
        cyc("mc_hold", 0, 8'hE0, 1, 8'h40, 3'd6, 1, 0);
        cyc("mc_rel",  0, 8'hA0, 1, 8'h00, 3'd6, 0, 0);
        cyc("mc_gap",  0, 8'hA0, 1, 8'h00, 3'd6, 0, 0);
        cyc("mc_g5",   0, 8'hA0, 1, 8'h20, 3'd5, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/enc_req_arbiter.md
Name: enc_req_arbiter

Overview:
- Sequential 8-way arbiter that shares one downstream resource (bus or port) among up to 8 requesters.
- Resolves contention with MSB-first priority selection: the highest index wins, the same convention as the team's 8:3 priority encoder.
- Selectable fixed or round-robin mode; the grant is held until released, with a bounded hold time.
- Sits between requesters and the shared resource. Outputs a one-hot grant plus the encoded id that drives the resource mux select.

Parameters:
- N, 8, number of requesters (fixed at 8 in this revision).
- IDW, 3, grant id width, equal to clog2(N).
- MAX_HOLD, 16, maximum consecutive GRANT cycles before a forced release (must be at least 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- req  in  8  request vector, level-sensitive; req[i] is held high while requester i wants or holds the resource.
- mode  in  1  0 = fixed priority, 1 = round robin; sampled only in IDLE.
- gnt  out  8  one-hot grant, registered.
- gnt_id  out  3  encoded index of the granted requester, registered.
- gnt_valid  out  1  high while any grant is active.
- preempt  out  1  one-cycle pulse when a grant is force-released by the hold limit.

Behaviour:
- States: IDLE, GRANT, GAP. All outputs are registered.
- Reset: state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, preempt=0, last_id=0, hold_cnt=0, mask=0. Reset is effective at the edge it is sampled, including mid-GRANT; the grant drops the next cycle with no preempt pulse.
- IDLE:
  - eff = req & ~mask. If eff==0, stay in IDLE.
  - Otherwise pick the winner k, go to GRANT, set gnt=1<<k, gnt_id=k, gnt_valid=1, hold_cnt=1, last_id=k, mask=0.
  - Latency: req seen at edge t gives gnt visible after edge t (1 cycle).
- Winner selection:
  - Fixed mode: the highest set index in eff.
  - Round-robin mode: search order last_id-1, last_id-2, ..., 0, 7, ..., last_id (mod 8). With last_id=0 after reset, the order is 7..0, identical to fixed mode.
- GRANT:
  - Requests from other indices are ignored.
  - If req[gnt_id]==0: go to GAP, clear gnt and gnt_valid.
  - Else if hold_cnt==MAX_HOLD: go to GAP, clear gnt and gnt_valid, pulse preempt=1, set mask=1<<gnt_id.
  - Else hold_cnt++.
  - If release and hold limit coincide (req drops on the MAX_HOLD cycle), it counts as a normal release: no preempt, no mask.
- GAP: exactly one dead cycle for resource turnaround with gnt=0, then IDLE. Minimum spacing between grants is 2 idle-grant cycles.
- Mask: clears on the next successful arbitration. If req & ~mask == 0 while mask is set, the mask also clears and the preempted requester may win on the following IDLE cycle.
- mode changes outside IDLE are ignored until the next IDLE evaluation.
- hold_cnt width is clog2(MAX_HOLD+1) and it never wraps.
- gnt is always one-hot or zero. gnt_id is held at its last value when gnt_valid=0.

Decomposition:
- Package enc_arb_pkg holds:
  - state enum: IDLE, GRANT, GAP.
  - constants N=8, IDW=3.
  - a function converting an id to one-hot.
- Sub-module rot_prio_pick (combinational):
  - Inputs: eff[7:0], start_id[2:0], rr_en.
  - Outputs: hit and id[2:0].
  - Rotates eff so start_id-1 is the MSB, applies an MSB-first priority encode, then un-rotates.
  - With rr_en=0 it is a plain MSB-first encode.

Test Plan:
- Fixed select: mode=0, req=8'b0010_0101 from IDLE -> next cycle gnt=8'b0010_0000, gnt_id=5, gnt_valid=1. Drop req[5] -> GAP cycle with gnt=0, then IDLE, then gnt_id=2.
- Empty/reset: req=0 for 10 cycles -> gnt_valid stays 0. Assert rst during a GRANT on id 3 -> gnt=0, gnt_valid=0, preempt=0 next cycle, state IDLE.
- Hold limit: MAX_HOLD=16, req=8'b0010_0101 held constant, mode=0 -> gnt_id=5 for exactly 16 cycles, preempt=1 for 1 cycle, GAP, then gnt_id=2 (5 masked). After id 2 releases, id 5 wins again.
- Coincident release: req[5] drops exactly on hold_cnt==16 -> preempt stays 0, no mask, next winner is the highest remaining requester.
- Round robin: mode=1, grant id 5 then release, req=8'b1010_0001 -> next gnt_id=0 (order 4,3,2,1,0,7,6,5). Next, with req=8'b1010_0000 -> gnt_id=7, then 5.
- Mode change mid-grant: toggle mode 0->1 while id 6 is granted -> arbitration during the grant is unaffected. At the next IDLE, round-robin order starts from last_id=6.
